// File: rtl/ram_bram_responder.sv
// BRAM-backed stand-in for the DDR RAM wrapper: serves edge-triggered write pulses and
// read-request/acknowledge cycles one at a time, with one-deep pending slots per direction.
module ram_bram_responder #(
   parameter int ADDR_W       = 26,
   parameter int DATA_W       = 8,
   parameter int DEPTH_LOG2   = 14,
   parameter int READ_LATENCY = 2,
   parameter int INIT_CYCLES  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   input  logic              write_enable,
   input  logic              read_request,
   input  logic              read_ack,
   output logic [DATA_W-1:0] data_out,
   output logic              rdy,
   output logic              rd_data_pres,
   output logic [ADDR_W-1:0] max_ram_address,
   output logic              overrun
);

   localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'((64'd1 << DEPTH_LOG2) - 64'd1);
   localparam int IW = $clog2(INIT_CYCLES + 1);
   localparam int LW = $clog2(READ_LATENCY + 1);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITE, S_RD_WAIT, S_RD_HOLD} state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

   logic              we_q, rr_q, ack_q;
   logic              we_ev, rr_ev, ack_ev;
   logic              pw_valid, pr_valid;
   logic [ADDR_W-1:0] pw_addr, pr_addr, op_addr;
   logic [DATA_W-1:0] pw_data, op_data;
   logic [IW-1:0]     init_cnt;
   logic [LW-1:0]     lat_cnt;
   logic              init_done, lat_done, op_in_range;
   logic              take_pw, take_we, take_pr, take_rr;
   logic              store_pw, store_pr, drop_ev;

   assign we_ev           = write_enable & ~we_q;
   assign rr_ev           = read_request & ~rr_q;
   assign ack_ev          = read_ack & ~ack_q;
   assign init_done       = (init_cnt == IW'(INIT_CYCLES - 1));
   assign lat_done        = (lat_cnt == LW'(READ_LATENCY - 1));
   assign op_in_range     = (op_addr <= MAX_ADDR);
   assign max_ram_address = MAX_ADDR;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_INIT;
      else        state <= state_nxt;
   end

   // NOTE: every comb output gets a default first, otherwise an unassigned path infers a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_INIT:    if (init_done) state_nxt = S_IDLE;
         S_IDLE: begin
            if (take_pw || take_we)      state_nxt = S_WRITE;
            else if (take_pr || take_rr) state_nxt = S_RD_WAIT;
         end
         S_WRITE:   state_nxt = S_IDLE;
         S_RD_WAIT: if (lat_done) state_nxt = S_RD_HOLD;
         S_RD_HOLD: if (ack_ev) state_nxt = S_IDLE;
         default:   state_nxt = S_INIT;
      endcase
   end

   // IDLE arbitration: pending write, write event, pending read, read event. Unserved events park.
   always_comb begin
      take_pw  = 1'b0;
      take_we  = 1'b0;
      take_pr  = 1'b0;
      take_rr  = 1'b0;
      if (state == S_IDLE) begin
         if (pw_valid)      take_pw = 1'b1;
         else if (we_ev)    take_we = 1'b1;
         else if (pr_valid) take_pr = 1'b1;
         else if (rr_ev)    take_rr = 1'b1;
      end
      store_pw = (state != S_INIT) && we_ev && !take_we && !(pw_valid && !take_pw);
      store_pr = (state != S_INIT) && rr_ev && !take_rr && !(pr_valid && !take_pr);
      drop_ev  = (state != S_INIT) &&
                 ((we_ev && !take_we && pw_valid && !take_pw) ||
                  (rr_ev && !take_rr && pr_valid && !take_pr));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q         <= 1'b0;
         rr_q         <= 1'b0;
         ack_q        <= 1'b0;
         pw_valid     <= 1'b0;
         pr_valid     <= 1'b0;
         pw_addr      <= '0;
         pw_data      <= '0;
         pr_addr      <= '0;
         op_addr      <= '0;
         op_data      <= '0;
         init_cnt     <= '0;
         lat_cnt      <= '0;
         data_out     <= '0;
         rdy          <= 1'b0;
         rd_data_pres <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         we_q  <= write_enable;
         rr_q  <= read_request;
         ack_q <= read_ack;

         if (state == S_INIT && !init_done) init_cnt <= init_cnt + 1'b1;
         if (state == S_INIT && init_done)  rdy <= 1'b1;

         if (take_pw) begin
            op_addr  <= pw_addr;
            op_data  <= pw_data;
            pw_valid <= 1'b0;
         end else if (take_we) begin
            op_addr <= address;
            op_data <= data_in;
         end else if (take_pr) begin
            op_addr  <= pr_addr;
            pr_valid <= 1'b0;
         end else if (take_rr) begin
            op_addr <= address;
         end

         // A slot freed this cycle may be refilled by a new event on the same edge.
         if (store_pw) begin
            pw_valid <= 1'b1;
            pw_addr  <= address;
            pw_data  <= data_in;
         end
         if (store_pr) begin
            pr_valid <= 1'b1;
            pr_addr  <= address;
         end
         if (drop_ev) overrun <= 1'b1;

         if (take_pr || take_rr)  lat_cnt <= '0;
         else if (state == S_RD_WAIT) lat_cnt <= lat_cnt + 1'b1;

         if (state == S_RD_WAIT && lat_done) begin
            data_out     <= op_in_range ? mem[op_addr[DEPTH_LOG2-1:0]] : '0;
            rd_data_pres <= 1'b1;
         end else if (state == S_RD_HOLD && ack_ev) begin
            rd_data_pres <= 1'b0;
         end
      end
   end

   // NOTE: the memory array has no reset; contents survive reset and it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (state == S_WRITE && op_in_range) mem[op_addr[DEPTH_LOG2-1:0]] <= op_data;
   end

endmodule

// File: tb/tb_ram_bram_responder.sv
// Self-checking bench for ram_bram_responder: directed scenarios plus randomized
// write/read traffic checked against an associative-array memory model.
module tb_ram_bram_responder;

   localparam int   ADDR_W = 26;
   localparam int   DATA_W = 8;
   localparam int   LAT    = 2;
   localparam int   INIT_N = 16;
   localparam logic [ADDR_W-1:0] MAX_A = 26'h0003FFF;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [ADDR_W-1:0] address = '0;
   logic [DATA_W-1:0] data_in = '0;
   logic              write_enable = 1'b0;
   logic              read_request = 1'b0;
   logic              read_ack = 1'b0;
   logic [DATA_W-1:0] data_out;
   logic              rdy, rd_data_pres, overrun;
   logic [ADDR_W-1:0] max_ram_address;

   int n_vec = 0;
   int n_err = 0;

   logic [DATA_W-1:0] model_mem [int];
   logic [ADDR_W-1:0] pool [8];

   ram_bram_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(14),
      .READ_LATENCY(LAT), .INIT_CYCLES(INIT_N)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .data_in(data_in),
      .write_enable(write_enable), .read_request(read_request), .read_ack(read_ack),
      .data_out(data_out), .rdy(rdy), .rd_data_pres(rd_data_pres),
      .max_ram_address(max_ram_address), .overrun(overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
      int idx = int'(a[13:0]);
      if (a > MAX_A) return '0;
      if (model_mem.exists(idx)) return model_mem[idx];
      return '0;
   endfunction

   function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (a <= MAX_A) model_mem[int'(a[13:0])] = d;
   endfunction

   task automatic wait_rdy(input string tag);
      int cnt = 0;
      bit saw_pres = 0;
      while (!rdy && cnt < 40) begin
         tick();
         cnt++;
         if (rd_data_pres) saw_pres = 1;
      end
      check({tag, "_init_len"}, 32'(cnt), 32'(INIT_N));
      check({tag, "_no_stale_pres"}, 32'(saw_pres), 32'd0);
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      address = a;
      data_in = d;
      write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
      tick();
      model_write(a, d);
   endtask

   // Waits (bounded) for rd_data_pres; exp_lat > 0 checks exact edges after the request edge.
   task automatic wait_data(input int exp_lat, input logic [DATA_W-1:0] exp_d, input string tag);
      int cyc = 0;
      while (!rd_data_pres && cyc < 40) begin
         tick();
         cyc++;
      end
      if (exp_lat > 0) check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
      else             check({tag, "_pres"}, 32'(rd_data_pres), 32'd1);
      check({tag, "_data"}, 32'(data_out), 32'(exp_d));
   endtask

   task automatic do_ack(input string tag);
      read_ack = 1'b1;
      tick();
      check({tag, "_ack_clr"}, 32'(rd_data_pres), 32'd0);
      read_ack = 1'b0;
      tick();
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a, input string tag);
      logic [DATA_W-1:0] exp_d = model_read(a);
      address = a;
      read_request = 1'b1;
      tick();
      read_request = 1'b0;
      wait_data(LAT, exp_d, tag);
      do_ack(tag);
   endtask

   initial begin
      // Reset state
      tick();
      check("rst_rdy", 32'(rdy), 32'd0);
      check("rst_pres", 32'(rd_data_pres), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);
      check("rst_dout", 32'(data_out), 32'd0);
      check("max_addr", 32'(max_ram_address), 32'h3FFF);
      reset = 1'b1;
      wait_rdy("boot");
      check("boot_ovr", 32'(overrun), 32'd0);

      // Basic write/read with hold and acknowledge
      do_write(26'h10, 8'hA5);
      address = 26'h10;
      read_request = 1'b1;
      tick();
      read_request = 1'b0;
      wait_data(LAT, 8'hA5, "rd10");
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_pres", 32'(rd_data_pres), 32'd1);
         check("hold_data", 32'(data_out), 32'hA5);
      end
      do_ack("rd10");
      check("dout_kept", 32'(data_out), 32'hA5);

      // Out-of-range access aliases low bits but must be dropped / return zero
      do_write(26'h3FF0, 8'h77);
      do_write(26'h1FFFFF0, 8'h3C);
      do_read(26'h1FFFFF0, "oor_rd");
      do_read(26'h3FF0, "alias_rd");

      // Write and read events on the same edge: write commits first
      address = 26'h20;
      data_in = 8'h11;
      write_enable = 1'b1;
      read_request = 1'b1;
      tick();
      write_enable = 1'b0;
      read_request = 1'b0;
      model_write(26'h20, 8'h11);
      wait_data(0, 8'h11, "same_edge");
      do_ack("same_edge");
      check("same_edge_ovr", 32'(overrun), 32'd0);

      // Two writes during RD_HOLD: first pends, second is dropped
      do_write(26'h2, 8'h99);
      address = 26'h10;
      read_request = 1'b1;
      tick();
      read_request = 1'b0;
      wait_data(LAT, 8'hA5, "hold_rd");
      address = 26'h1; data_in = 8'h01; write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
      tick();
      address = 26'h2; data_in = 8'h02; write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
      tick();
      check("ovr_set", 32'(overrun), 32'd1);
      model_write(26'h1, 8'h01);
      do_ack("hold_rd");
      tick();
      tick();
      do_read(26'h1, "pend_wr");
      do_read(26'h2, "drop_wr");
      check("ovr_sticky", 32'(overrun), 32'd1);

      // Reset during RD_WAIT
      address = 26'h10;
      read_request = 1'b1;
      tick();
      read_request = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("async_rdy", 32'(rdy), 32'd0);
      check("async_pres", 32'(rd_data_pres), 32'd0);
      check("async_ovr", 32'(overrun), 32'd0);
      tick();
      tick();
      reset = 1'b1;
      wait_rdy("rerun");
      do_read(26'h10, "bram_kept");

      // Randomized traffic against the model
      for (int i = 0; i < 8; i++) begin
         pool[i] = ADDR_W'($urandom_range(0, 16383));
         do_write(pool[i], DATA_W'($urandom));
      end
      for (int it = 0; it < 150; it++) begin
         int k = int'($urandom_range(0, 9));
         logic [ADDR_W-1:0] a = pool[$urandom_range(0, 7)];
         logic [DATA_W-1:0] d = DATA_W'($urandom);
         if ($urandom_range(0, 4) == 0)
            a = ADDR_W'(($urandom_range(1, 4095) << 14) | int'(a[13:0]));
         if (k < 4) begin
            do_write(a, d);
         end else if (k < 8) begin
            do_read(a, "rnd_rd");
         end else if (k == 8) begin
            address = a;
            data_in = d;
            write_enable = 1'b1;
            read_request = 1'b1;
            tick();
            write_enable = 1'b0;
            read_request = 1'b0;
            model_write(a, d);
            wait_data(0, model_read(a), "rnd_combo");
            do_ack("rnd_combo");
         end else begin
            read_ack = 1'b1;
            tick();
            read_ack = 1'b0;
            tick();
            check("stray_ack_pres", 32'(rd_data_pres), 32'd0);
            do_read(a, "rnd_after_ack");
         end
      end
      check("final_ovr", 32'(overrun), 32'd0);
      check("final_rdy", 32'(rdy), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
